// File: rtl/elev_call_sched_if.sv
// elev_call_sched_if
//   Groups the scheduler's call/car inputs and its target/status outputs.
//   Signal prefixes are relative to the scheduler: i_* flow into it, o_* out of it.
//   Ports (via modports):
//     slave  - the scheduler: reads i_call_btn, i_car_floor, i_car_door;
//              drives o_target, o_target_valid, o_pending, o_dir_up, o_busy, o_fault
//     master - the car side / environment: the opposite directions
interface elev_call_sched_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
  logic [NUM_FLOORS-1:0] i_call_btn;
  logic [FLOOR_W-1:0]    i_car_floor;
  logic                  i_car_door;
  logic [NUM_FLOORS-1:0] o_target;
  logic                  o_target_valid;
  logic [NUM_FLOORS-1:0] o_pending;
  logic                  o_dir_up;
  logic                  o_busy;
  logic                  o_fault;

  modport slave (
    input  i_call_btn, i_car_floor, i_car_door,
    output o_target, o_target_valid, o_pending, o_dir_up, o_busy, o_fault
  );

  modport master (
    output i_call_btn, i_car_floor, i_car_door,
    input  o_target, o_target_valid, o_pending, o_dir_up, o_busy, o_fault
  );
endinterface

// File: rtl/elev_call_sched.sv
// elev_call_sched
//   Latches floor calls into sticky pending bits and serves them one at a time
//   in SCAN order: keep going in the current direction, reverse only when
//   nothing is left ahead. Drives a one-hot target to the car controller,
//   holds the door for DWELL_CYCLES after arrival, then clears the served call.
//   A dispatch that does not arrive within TIMEOUT_CYCLES raises a sticky fault.
//   Optional build macro ELEV_SCHED_PARK_EN: after PARK_CYCLES idle cycles with
//   no calls and the car away from floor 0, send the car to floor 0.
//   Ports:
//     i_clk  - system clock
//     i_rst  - asynchronous active-high reset
//     bus    - elev_call_sched_if.slave (calls, car position/door, target, status)
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no target; pick the next floor as soon as anything is pending
//   DISPATCH | target held stable until the car arrives with door open
//   DWELL    | target dropped, door held for DWELL_CYCLES, then call cleared
module elev_call_sched #(
  parameter int NUM_FLOORS     = 4,
  parameter int FLOOR_W        = $clog2(NUM_FLOORS),
  parameter int DWELL_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PARK_CYCLES    = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  elev_call_sched_if.slave bus
);
  localparam int TMR_MAX = (TIMEOUT_CYCLES > DWELL_CYCLES) ? TIMEOUT_CYCLES : DWELL_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [NUM_FLOORS-1:0] ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16 || DWELL_CYCLES < 1 || TIMEOUT_CYCLES < 1 || PARK_CYCLES < 1) begin : g_bad_param
    $error("elev_call_sched: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DWELL} state_t;

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] r_target;
  logic                  r_target_valid;
  logic                  r_dir_up;
  logic                  r_fault;
  logic [FLOOR_W-1:0]    r_sel_idx;
  logic [TMR_W-1:0]      r_timer;   // shared: dispatch timeout and dwell, never both active

  logic [31:0]           w_floor_ext;
  logic                  w_here, w_up_found, w_dn_found;
  logic [FLOOR_W-1:0]    w_up_idx, w_dn_idx, w_sel_idx;
  logic                  w_sel_dir_up;
  logic                  w_arrived;
  logic [NUM_FLOORS-1:0] w_served_mask;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_parking;

  assign w_floor_ext = 32'(bus.i_car_floor);

  // Lowest pending floor above the car, highest pending floor below it.
  // An out-of-range car_floor sees every pending floor as "below".
  always_comb begin
    w_here     = 1'b0;
    w_up_found = 1'b0;
    w_dn_found = 1'b0;
    w_up_idx   = '0;
    w_dn_idx   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i]) begin
        if ($unsigned(i) == w_floor_ext) begin
          w_here = 1'b1;
        end else if ($unsigned(i) > w_floor_ext) begin
          if (!w_up_found) begin
            w_up_found = 1'b1;
            w_up_idx   = FLOOR_W'(i);
          end
        end else begin
          w_dn_found = 1'b1;
          w_dn_idx   = FLOOR_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_idx    = bus.i_car_floor;
    w_sel_dir_up = r_dir_up;
    if (!w_here) begin
      if (r_dir_up) begin
        if (w_up_found) begin
          w_sel_idx = w_up_idx;
        end else begin
          w_sel_idx    = w_dn_idx;
          w_sel_dir_up = 1'b0;
        end
      end else begin
        if (w_dn_found) begin
          w_sel_idx = w_dn_idx;
        end else begin
          w_sel_idx    = w_up_idx;
          w_sel_dir_up = 1'b1;
        end
      end
    end
  end

  // r_sel_idx is always a legal floor, so an out-of-range car_floor never matches.
  assign w_arrived     = bus.i_car_door && (bus.i_car_floor == r_sel_idx);
  assign w_served_mask = ONE << r_sel_idx;

  always_comb begin
    w_clr = '0;
    if (r_state == ST_DWELL && r_timer == '0)
      w_clr = w_served_mask;
    if (r_state == ST_DISPATCH && !w_arrived && r_timer == '0 && !w_parking)
      w_clr = w_served_mask;
  end

`ifdef ELEV_SCHED_PARK_EN
  localparam int PK_W = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
  logic [PK_W-1:0] r_park_cnt;
  logic            r_parking;
  logic            w_park_ok;
  logic            w_park_go;

  assign w_park_ok = (r_state == ST_IDLE) && (r_pending == '0) && (bus.i_call_btn == '0) &&
                     (bus.i_car_floor != '0);
  assign w_park_go = w_park_ok && (r_park_cnt == PK_W'(PARK_CYCLES - 1));
  assign w_parking = r_parking;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_park_cnt <= '0;
    else if (!w_park_ok || w_park_go)
      r_park_cnt <= '0;
    else
      r_park_cnt <= r_park_cnt + 1'b1;
  end
`else
  assign w_parking = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_pending      <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_dir_up       <= 1'b1;
      r_fault        <= 1'b0;
      r_sel_idx      <= '0;
      r_timer        <= '0;
`ifdef ELEV_SCHED_PARK_EN
      r_parking      <= 1'b0;
`endif
    end else begin
      r_pending <= (r_pending | bus.i_call_btn) & ~w_clr;
      case (r_state)
        ST_IDLE: begin
          if (r_pending != '0) begin
            r_state        <= ST_DISPATCH;
            r_sel_idx      <= w_sel_idx;
            r_dir_up       <= w_sel_dir_up;
            r_target       <= ONE << w_sel_idx;
            r_target_valid <= 1'b1;
            r_timer        <= TMR_W'(TIMEOUT_CYCLES - 1);
          end
`ifdef ELEV_SCHED_PARK_EN
          else if (w_park_go) begin
            r_state        <= ST_DISPATCH;
            r_sel_idx      <= '0;
            r_target       <= ONE;
            r_target_valid <= 1'b1;
            r_timer        <= TMR_W'(TIMEOUT_CYCLES - 1);
            r_parking      <= 1'b1;
          end
`endif
        end
        ST_DISPATCH: begin
          if (w_arrived) begin
            r_target       <= '0;
            r_target_valid <= 1'b0;
            if (w_parking) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DWELL;
              r_timer <= TMR_W'(DWELL_CYCLES - 1);
            end
          end else if (r_timer == '0) begin
            r_fault        <= 1'b1;
            r_target       <= '0;
            r_target_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
`ifdef ELEV_SCHED_PARK_EN
          if (w_arrived || r_timer == '0)
            r_parking <= 1'b0;
`endif
        end
        ST_DWELL: begin
          if (r_timer == '0)
            r_state <= ST_IDLE;
          else
            r_timer <= r_timer - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_target       = r_target;
  assign bus.o_target_valid = r_target_valid;
  assign bus.o_pending      = r_pending;
  assign bus.o_dir_up       = r_dir_up;
  assign bus.o_busy         = (r_state != ST_IDLE);
  assign bus.o_fault        = r_fault;
endmodule

// File: tb/tb_elev_call_sched.sv
// tb_elev_call_sched
//   Self-checking bench for elev_call_sched with NUM_FLOORS=4, DWELL_CYCLES=4,
//   TIMEOUT_CYCLES=16, PARK_CYCLES=8. Expected dispatches (target + direction)
//   are queued when calls are driven and popped when the DUT raises a target.
module tb_elev_call_sched;
  localparam int NF = 4;
  localparam int FW = $clog2(NF);
  localparam int DW = 4;
  localparam int TO = 16;
  localparam int PK = 8;

  typedef struct packed {
    logic [NF-1:0] tgt;
    logic          dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  elev_call_sched_if #(.NUM_FLOORS(NF)) bus_if ();

  elev_call_sched #(
    .NUM_FLOORS(NF), .DWELL_CYCLES(DW), .TIMEOUT_CYCLES(TO), .PARK_CYCLES(PK)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic apply_reset(input string name);
    @(negedge clk);
    bus_if.i_call_btn  = '0;
    bus_if.i_car_floor = '0;
    bus_if.i_car_door  = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.o_target, bus_if.o_target_valid, bus_if.o_pending, bus_if.o_dir_up,
         bus_if.o_busy, bus_if.o_fault} !== {4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: target=%b valid=%b pending=%b dir_up=%b busy=%b fault=%b, required 0000 0 0000 1 0 0",
               name, bus_if.o_target, bus_if.o_target_valid, bus_if.o_pending,
               bus_if.o_dir_up, bus_if.o_busy, bus_if.o_fault);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // One-cycle button pulse; starts and ends at a negedge.
  task automatic press(input logic [NF-1:0] m);
    bus_if.i_call_btn = m;
    @(negedge clk);
    bus_if.i_call_btn = '0;
  endtask

  // Waits for a target, compares it against the scoreboard, drives the car to
  // it and checks dwell length and the pending clear. With repress set, the
  // same floor is pressed again on the last dwell cycle.
  task automatic serve_one(input bit repress);
    exp_t e;
    bit   seen;
    int   n;
    int   idx;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus_if.o_target_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || exp_q.size() == 0) begin
      errors++;
      $display("FAIL dispatch_wait: target_valid=%b queued=%0d, required target_valid=1 with an expected entry",
               bus_if.o_target_valid, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (bus_if.o_target !== e.tgt) begin
      errors++;
      $display("FAIL scan_target: got %b, required %b", bus_if.o_target, e.tgt);
    end
    checks++;
    if (bus_if.o_dir_up !== e.dir) begin
      errors++;
      $display("FAIL scan_dir: got %b, required %b (target %b)", bus_if.o_dir_up, e.dir, e.tgt);
    end
    idx = 0;
    for (int i = 0; i < NF; i++) if (e.tgt[i]) idx = i;
    bus_if.i_car_floor = FW'(idx);
    bus_if.i_car_door  = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus_if.i_call_btn = '0;
      if (!(bus_if.o_busy === 1'b1 && bus_if.o_target_valid === 1'b0)) break;
      n++;
      if (repress && n == DW) bus_if.i_call_btn = e.tgt;
    end
    bus_if.i_call_btn = '0;
    bus_if.i_car_door = 1'b0;
    checks++;
    if (n != DW) begin
      errors++;
      $display("FAIL dwell_len: got %0d cycles, required %0d", n, DW);
    end
    checks++;
    if ((bus_if.o_pending & e.tgt) !== '0) begin
      errors++;
      $display("FAIL served_clear: pending=%b still has served floor %b", bus_if.o_pending, e.tgt);
    end
  endtask

  task automatic test_reset_idle();
    apply_reset("reset_state");
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_if.o_target, bus_if.o_pending, bus_if.o_dir_up, bus_if.o_busy} !== {4'b0000, 4'b0000, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d target=%b pending=%b dir_up=%b busy=%b, required 0000 0000 1 0",
                 k, bus_if.o_target, bus_if.o_pending, bus_if.o_dir_up, bus_if.o_busy);
      end
    end
  endtask

  task automatic test_single_call();
    apply_reset("reset_single");
    exp_q.push_back('{tgt: 4'b0100, dir: 1'b1});
    press(4'b0100);
    checks++;
    if (bus_if.o_pending !== 4'b0100 || bus_if.o_target !== 4'b0000) begin
      errors++;
      $display("FAIL call_latch: pending=%b target=%b, required pending=0100 target=0000",
               bus_if.o_pending, bus_if.o_target);
    end
    @(negedge clk);
    checks++;
    if (bus_if.o_target !== 4'b0100 || bus_if.o_target_valid !== 1'b1) begin
      errors++;
      $display("FAIL target_latency: target=%b valid=%b, required 0100 1", bus_if.o_target, bus_if.o_target_valid);
    end
    serve_one(1'b0);
    checks++;
    if (bus_if.o_busy !== 1'b0 || bus_if.o_pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_done: busy=%b pending=%b, required 0 0000", bus_if.o_busy, bus_if.o_pending);
    end
  endtask

  task automatic test_scan_order();
    int k;
    apply_reset("reset_scan");
    bus_if.i_car_floor = FW'(1);
    exp_q.push_back('{tgt: 4'b1000, dir: 1'b1});
    exp_q.push_back('{tgt: 4'b0100, dir: 1'b0});
    exp_q.push_back('{tgt: 4'b0001, dir: 1'b0});
    press(4'b1001);
    for (k = 0; k < 10 && bus_if.o_target_valid !== 1'b1; k++) @(negedge clk);
    press(4'b0100);
    checks++;
    if (bus_if.o_target !== 4'b1000 || bus_if.o_pending !== 4'b1101) begin
      errors++;
      $display("FAIL no_retarget: target=%b pending=%b, required 1000 1101", bus_if.o_target, bus_if.o_pending);
    end
    repeat (3) serve_one(1'b0);
  endtask

  task automatic test_clear_vs_press();
    apply_reset("reset_clear");
    exp_q.push_back('{tgt: 4'b0100, dir: 1'b1});
    press(4'b0100);
    serve_one(1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.o_target_valid !== 1'b0 || bus_if.o_pending[2] !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: valid=%b pending=%b, required valid=0 pending[2]=0",
               bus_if.o_target_valid, bus_if.o_pending);
    end
  endtask

  task automatic test_all_buttons();
    apply_reset("reset_all");
    bus_if.i_car_floor = FW'(2);
    exp_q.push_back('{tgt: 4'b0100, dir: 1'b1});
    exp_q.push_back('{tgt: 4'b1000, dir: 1'b1});
    exp_q.push_back('{tgt: 4'b0010, dir: 1'b0});
    exp_q.push_back('{tgt: 4'b0001, dir: 1'b0});
    press(4'b1111);
    repeat (4) serve_one(1'b0);
    // Car now at floor 0 heading down: a call above must flip direction.
    exp_q.push_back('{tgt: 4'b0100, dir: 1'b1});
    press(4'b0100);
    serve_one(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    int k;
    apply_reset("reset_timeout");
    press(4'b1000);
    for (k = 0; k < 10 && bus_if.o_target_valid !== 1'b1; k++) @(negedge clk);
    n = 0;
    while (bus_if.o_target_valid === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_len: dispatch lasted %0d cycles, required %0d", n, TO);
    end
    checks++;
    if (bus_if.o_fault !== 1'b1 || bus_if.o_target !== 4'b0000 || bus_if.o_pending[3] !== 1'b0 ||
        bus_if.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: fault=%b target=%b pending=%b busy=%b, required 1 0000 0xxx 0",
               bus_if.o_fault, bus_if.o_target, bus_if.o_pending, bus_if.o_busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus_if.o_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b, required 1", bus_if.o_fault);
    end
    press(4'b0010);
    for (k = 0; k < 10 && bus_if.o_target_valid !== 1'b1; k++) @(negedge clk);
    checks++;
    if (bus_if.o_target !== 4'b0010) begin
      errors++;
      $display("FAIL pre_abort_target: got %b, required 0010", bus_if.o_target);
    end
    apply_reset("async_abort");
  endtask

  task automatic test_park();
    int n;
    apply_reset("reset_park");
    bus_if.i_car_floor = FW'(3);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (bus_if.o_target_valid === 1'b1) break;
    end
`ifdef ELEV_SCHED_PARK_EN
    checks++;
    if (n != PK || bus_if.o_target !== 4'b0001) begin
      errors++;
      $display("FAIL park_issue: after %0d cycles target=%b, required %0d cycles target=0001",
               n, bus_if.o_target, PK);
    end
    bus_if.i_car_floor = '0;
    bus_if.i_car_door  = 1'b1;
    @(negedge clk);
    bus_if.i_car_door  = 1'b0;
    checks++;
    if (bus_if.o_busy !== 1'b0 || bus_if.o_target !== 4'b0000 || bus_if.o_pending !== 4'b0000) begin
      errors++;
      $display("FAIL park_arrive: busy=%b target=%b pending=%b, required 0 0000 0000",
               bus_if.o_busy, bus_if.o_target, bus_if.o_pending);
    end
`else
    checks++;
    if (bus_if.o_target !== 4'b0000 || bus_if.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_park: after %0d cycles target=%b busy=%b, required 0000 0", n,
               bus_if.o_target, bus_if.o_busy);
    end
`endif
  endtask

  initial begin
    bus_if.i_call_btn  = '0;
    bus_if.i_car_floor = '0;
    bus_if.i_car_door  = 1'b0;
    test_reset_idle();
    test_single_call();
    test_scan_order();
    test_clear_vs_press();
    test_all_buttons();
    test_timeout();
    test_park();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/elev_call_sched.md
Name: elev_call_sched

Overview:
Request scheduler that sits in front of the car controller. It latches momentary floor-call buttons into sticky pending bits and picks one target floor at a time using SCAN order (keep travelling in the current direction, reverse only when nothing is left ahead). It drives a one-hot target vector to the car controller and holds the door dwell time, then clears the served call.

Parameters:
NUM_FLOORS, 4, number of floors; legal range 2..16
FLOOR_W, $clog2(NUM_FLOORS), width of the floor index
DWELL_CYCLES, 8, cycles the door is held open after arrival; minimum 1
TIMEOUT_CYCLES, 1024, maximum cycles allowed in DISPATCH before a fault is raised
PARK_CYCLES, 64, idle cycles before parking; used only with ELEV_SCHED_PARK_EN

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
call_btn  in  NUM_FLOORS  raw call buttons; a one-cycle pulse is enough
car_floor  in  FLOOR_W  current car floor index, 0 = bottom
car_door  in  1  1 = car door open
target  out  NUM_FLOORS  one-hot floor request to the car controller; all zeros = no request
target_valid  out  1  1 while target is non-zero
pending  out  NUM_FLOORS  latched calls not yet served
dir_up  out  1  current SCAN direction; 1 = up
busy  out  1  state is not IDLE
fault  out  1  sticky; set on dispatch timeout

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, pending = 0, target = 0, target_valid = 0, dir_up = 1, busy = 0, fault = 0, all counters = 0. Reset asserted mid-operation aborts immediately, drops the target and loses all calls.
- Call latch: each cycle pending <= (pending | call_btn) & ~clr, where clr is the one-hot served floor at the end of DWELL. Clear wins over a press on the same floor in the same cycle. A press is visible on pending the next cycle.
- States: IDLE, DISPATCH, DWELL.
- IDLE: if pending == 0, stay. Otherwise select a floor and enter DISPATCH on the next edge, with target registered.
- Selection, evaluated in this order against car_floor:
  - (1) Pending bit at car_floor: select it.
  - (2) dir_up = 1: select the lowest pending floor above car_floor. If there is none, select the highest pending floor below and set dir_up = 0.
  - (3) dir_up = 0: select the highest pending floor below car_floor. If there is none, select the lowest pending floor above and set dir_up = 1.
- DISPATCH: target holds a stable one-hot value. New calls are latched but do not retarget the car. Arrival is car_floor == selected index and car_door == 1, sampled at a clock edge; on arrival go to DWELL with target = 0.
- DWELL: target = 0 so the car holds its door open. A counter runs DWELL_CYCLES cycles. On the last cycle, clear the served pending bit and return to IDLE. Exactly DWELL_CYCLES cycles are spent in DWELL.
- Timeout: a counter runs in DISPATCH. On reaching TIMEOUT_CYCLES, set fault, drop target, clear the selected pending bit and go to IDLE. fault stays set until rst.
- Boundaries:
  - At the top floor with dir_up = 1 and only lower calls pending: reverse direction.
  - At floor 0: symmetric.
  - car_floor values >= NUM_FLOORS are treated as not arrived.
  - All buttons pressed at once: served in SCAN order with no floor skipped.

Optional Feature:
ELEV_SCHED_PARK_EN
- Defined: after PARK_CYCLES consecutive cycles in IDLE with pending == 0 and car_floor != 0, issue target = floor 0 through DISPATCH. On arrival go straight to IDLE, with no DWELL and no pending clear. Any new call during a park dispatch is latched and served after arrival. The idle counter resets on any call.
- Not defined: with pending == 0 the block stays in IDLE indefinitely, and PARK_CYCLES is ignored.

Test Plan:
(All with NUM_FLOORS = 4, DWELL_CYCLES = 4.)
- Reset then idle: rst pulse, no buttons -> target = 0, pending = 0, dir_up = 1, busy = 0 for 100 cycles.
- Single call: car_floor = 0, pulse call_btn = 4'b0100 -> pending = 4'b0100 next cycle. target = 4'b0100 one cycle later. Drive car_floor = 2, car_door = 1 -> target = 0 for exactly 4 cycles, then pending = 0 and the block returns to IDLE.
- SCAN order: car at 1 with dir_up = 1, calls 4'b1001 -> floor 3 served first, then dir_up = 0 and floor 0 served.
- Clear vs press: re-press floor 2 on the last DWELL cycle for floor 2 -> pending bit 2 = 0 afterwards.
- Timeout: TIMEOUT_CYCLES = 16, call floor 3, car_floor held at 0 -> fault = 1 at cycle 16 of DISPATCH, target = 0, pending[3] = 0. Async rst mid-DISPATCH -> all outputs at reset values before the next clk edge.
- With ELEV_SCHED_PARK_EN, PARK_CYCLES = 8: car idle at floor 3 -> target = 4'b0001 after 8 idle cycles. Without the macro -> target stays 0.
